// File: rtl/seg_pkg.sv
// Shared segment patterns (active-low, bit0 = a) and scan FSM types for the
// seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {S_BLANK, S_ON} scan_state_e;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_out_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with blanking gap and
// frame-aligned double buffering. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk50MHz,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              Segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (BLANK_CYC >= SCAN_DIV || NUM_DIGITS < 1) begin : g_param_err
    $error("seven_seg_scan_ctrl: need NUM_DIGITS >= 1 and BLANK_CYC < SCAN_DIV");
  end

  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d, act_q, act_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                       pend_full_q, pend_full_d;

  seg_out_t              out_q, out_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q;

  logic last, commit, xfer, show, suppress;
  logic [3:0] nib;
  logic [6:0] pat;

  assign last   = (cnt_q == CNT_LAST);
  assign commit = en && (cnt_q == '0) && (idx_q == '0) && pend_full_q;
  assign xfer   = load_valid && !pend_full_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      case (state_q)
        S_BLANK: if (BLANK_CYC == 0 || cnt_q == BLANK_LAST) state_d = S_ON;
        S_ON:    if (last && BLANK_CYC != 0) state_d = S_BLANK;
        default: state_d = S_BLANK;
      endcase
    end
  end

  // Transfer and commit are exclusive: ready is low whenever a commit can fire.
  always_comb begin
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    act_dp_d    = act_dp_q;
    if (xfer) begin
      pend_d      = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end else if (commit) begin
      act_d       = pend_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  // Display from the post-commit buffer so a frame never shows stale digits.
  assign nib  = act_d[idx_q];
  assign show = en && (state_q == S_ON || BLANK_CYC == 0);

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS:0] lz;
  always_comb begin
    lz             = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) lz[i] = lz[i+1] && (act_d[i] == 4'h0);
  end
  assign suppress = lz[idx_q] && (idx_q != '0);
`else
  assign suppress = 1'b0;
`endif

  hex_to_7seg u_dec (
    .nib_i (nib),
    .seg_o (pat)
  );

  always_comb begin
    out_d = '{seg: SEG_BLANK, dp: 1'b1};
    an_d  = '1;
    if (show) begin
      an_d[idx_q] = 1'b0;
      out_d.seg   = suppress ? SEG_BLANK : pat;
      out_d.dp    = ~act_dp_d[idx_q];
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q     <= S_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
      act_dp_q    <= '0;
      out_q       <= '{seg: SEG_BLANK, dp: 1'b1};
      an_q        <= '1;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      act_dp_q    <= act_dp_d;
      out_q       <= out_d;
      an_q        <= an_d;
      fs_q        <= commit;
    end
  end

  assign load_ready  = ~pend_full_q;
  assign Segments    = out_q.seg;
  assign dp          = out_q.dp;
  assign an_n        = an_q;
  assign frame_start = fs_q;

endmodule
